// File: rtl/cmul_seq.sv
// cmul_seq: sequential complex-multiply front end. It accepts one operand set
// (A = a_re + j*a_im, W = w_re + j*w_im). It then drives the four partial
// products, one per cycle, through a single external combinational fpu_mul.
// The four products are held until the downstream stage takes them.
//
// Ports
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_valid / o_ready        operand handshake (o_ready only in IDLE)
//   i_32_a_re .. i_32_w_im   operand set
//   o_mul_a, o_mul_b         operands to the external fpu_mul (0 outside MUL)
//   i_mul_p                  fpu_mul product for the current o_mul_a/o_mul_b
//   o_32_rr/ii/ri/ir         a_re*w_re, a_im*w_im, a_re*w_im, a_im*w_re
//   o_valid / i_ready        product handshake (o_valid only in DONE)
//
// fpu_mul: combinational IEEE-754 binary32 multiplier. It rounds to nearest,
// ties to even. Denormal inputs and underflowing results are flushed to a
// signed zero. Any NaN input, or Inf*0, gives the quiet NaN 7fc00000.
//   i_32_a, i_32_b  operands
//   o_32_mul        product

module cmul_seq #(
  parameter int unsigned SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_32_a_re,
  input  logic [SIZE_DATA-1:0] i_32_a_im,
  input  logic [SIZE_DATA-1:0] i_32_w_re,
  input  logic [SIZE_DATA-1:0] i_32_w_im,
  output logic [SIZE_DATA-1:0] o_mul_a,
  output logic [SIZE_DATA-1:0] o_mul_b,
  input  logic [SIZE_DATA-1:0] i_mul_p,
  output logic [SIZE_DATA-1:0] o_32_rr,
  output logic [SIZE_DATA-1:0] o_32_ii,
  output logic [SIZE_DATA-1:0] o_32_ri,
  output logic [SIZE_DATA-1:0] o_32_ir,
  output logic                 o_valid,
  input  logic                 i_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state, state_n;
  logic [1:0]           cnt, cnt_n;
  logic [SIZE_DATA-1:0] a_re, a_im, w_re, w_im;
  logic [SIZE_DATA-1:0] a_re_n, a_im_n, w_re_n, w_im_n;
  logic [SIZE_DATA-1:0] rr_n, ii_n, ri_n, ir_n;
  logic [SIZE_DATA-1:0] mul_a_n, mul_b_n;

  // Next-state, operand capture, product capture and registered output values
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_re_n  = a_re;
    a_im_n  = a_im;
    w_re_n  = w_re;
    w_im_n  = w_im;
    rr_n    = o_32_rr;
    ii_n    = o_32_ii;
    ri_n    = o_32_ri;
    ir_n    = o_32_ir;
    mul_a_n = '0;
    mul_b_n = '0;

    case (state)
      IDLE: begin
        if (i_valid && o_ready) begin
          a_re_n  = i_32_a_re;
          a_im_n  = i_32_a_im;
          w_re_n  = i_32_w_re;
          w_im_n  = i_32_w_im;
          cnt_n   = 2'd0;
          state_n = MUL;
        end
      end
      MUL: begin
        case (cnt)
          2'd0:    rr_n = i_mul_p;
          2'd1:    ii_n = i_mul_p;
          2'd2:    ri_n = i_mul_p;
          default: ir_n = i_mul_p;
        endcase
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Multiplier operands are registered, so select them from next-cycle state
    if (state_n == MUL) begin
      case (cnt_n)
        2'd0:    begin mul_a_n = a_re_n; mul_b_n = w_re_n; end
        2'd1:    begin mul_a_n = a_im_n; mul_b_n = w_im_n; end
        2'd2:    begin mul_a_n = a_re_n; mul_b_n = w_im_n; end
        default: begin mul_a_n = a_im_n; mul_b_n = w_re_n; end
      endcase
    end
  end

  // State and output registers; reset aborts any in-flight set
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      a_re    <= '0;
      a_im    <= '0;
      w_re    <= '0;
      w_im    <= '0;
      o_32_rr <= '0;
      o_32_ii <= '0;
      o_32_ri <= '0;
      o_32_ir <= '0;
      o_mul_a <= '0;
      o_mul_b <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_re    <= a_re_n;
      a_im    <= a_im_n;
      w_re    <= w_re_n;
      w_im    <= w_im_n;
      o_32_rr <= rr_n;
      o_32_ii <= ii_n;
      o_32_ri <= ri_n;
      o_32_ir <= ir_n;
      o_mul_a <= mul_a_n;
      o_mul_b <= mul_b_n;
      o_valid <= (state_n == DONE);
      o_ready <= (state_n == IDLE);
    end
  end

endmodule

module fpu_mul #(
  parameter int unsigned SIZE_DATA = 32
) (
  input  logic [SIZE_DATA-1:0] i_32_a,
  input  logic [SIZE_DATA-1:0] i_32_b,
  output logic [SIZE_DATA-1:0] o_32_mul
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = SIZE_DATA - 1 - EXP_W;
  localparam int unsigned PROD_W = 2 * (MAN_W + 1);
  localparam int unsigned BIAS   = (2 ** (EXP_W - 1)) - 1;
  localparam int unsigned EMAX   = (2 ** EXP_W) - 1;

  logic              sign;
  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [PROD_W-1:0] prod;
  logic [MAN_W-1:0]  man;
  logic              guard, sticky, round_up;
  logic [MAN_W:0]    man_r;
  logic [EXP_W+1:0]  exp_s;

  // Unpack, multiply significands, normalise, round and classify
  always_comb begin
    sign   = i_32_a[SIZE_DATA-1] ^ i_32_b[SIZE_DATA-1];
    ea     = i_32_a[SIZE_DATA-2 -: EXP_W];
    eb     = i_32_b[SIZE_DATA-2 -: EXP_W];
    ma     = i_32_a[MAN_W-1:0];
    mb     = i_32_b[MAN_W-1:0];
    a_nan  = (&ea) && (|ma);
    b_nan  = (&eb) && (|mb);
    a_inf  = (&ea) && !(|ma);
    b_inf  = (&eb) && !(|mb);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    prod = PROD_W'({1'b1, ma}) * PROD_W'({1'b1, mb});

    // Leading one lands at the top bit when the product of significands is >= 2
    if (prod[PROD_W-1]) begin
      man    = prod[PROD_W-2 -: MAN_W];
      guard  = prod[PROD_W-2-MAN_W];
      sticky = |prod[PROD_W-3-MAN_W:0];
    end else begin
      man    = prod[PROD_W-3 -: MAN_W];
      guard  = prod[PROD_W-3-MAN_W];
      sticky = |prod[PROD_W-4-MAN_W:0];
    end

    round_up = guard && (sticky || man[0]);
    man_r    = {1'b0, man} + (MAN_W+1)'(round_up);

    // Biased exponent in a wider field; the top bit flags underflow
    exp_s = (EXP_W+2)'(ea) + (EXP_W+2)'(eb) + (EXP_W+2)'(prod[PROD_W-1])
          + (EXP_W+2)'(man_r[MAN_W]) - (EXP_W+2)'(BIAS);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      o_32_mul = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (a_inf || b_inf) begin
      o_32_mul = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero || exp_s[EXP_W+1] || (exp_s == '0)) begin
      o_32_mul = {sign, {(SIZE_DATA-1){1'b0}}};
    end else if (exp_s >= (EXP_W+2)'(EMAX)) begin
      o_32_mul = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      o_32_mul = {sign, exp_s[EXP_W-1:0], man_r[MAN_W-1:0]};
    end
  end

endmodule

// File: tb/tb_cmul_seq.sv
// Testbench for cmul_seq with a real fpu_mul in the multiplier loop.
// Table vectors plus directed reset, backpressure, busy and abort sequences;
// product transfers are checked against a scoreboard queue.

module tb_cmul_seq;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] rr;
    logic [W-1:0] ii;
    logic [W-1:0] ri;
    logic [W-1:0] ir;
  } prod_t;

  typedef struct {
    logic [W-1:0] a_re;
    logic [W-1:0] a_im;
    logic [W-1:0] w_re;
    logic [W-1:0] w_im;
    prod_t        exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, i_valid, o_ready, o_valid, i_ready;
  logic [W-1:0] a_re, a_im, w_re, w_im;
  logic [W-1:0] mul_a, mul_b, mul_p;
  logic [W-1:0] rr, ii, ri, ir;
  logic [W-1:0] ref_rr, ref_ii, ref_ri, ref_ir;

  prod_t sb[$];
  vec_t  vecs[4];
  prod_t busy_exp;
  int    errors = 0;
  int    checks = 0;
  int    valid_cycles = 0;

  always #5 clk = ~clk;

  cmul_seq #(.SIZE_DATA(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_32_a_re (a_re),
    .i_32_a_im (a_im),
    .i_32_w_re (w_re),
    .i_32_w_im (w_im),
    .o_mul_a   (mul_a),
    .o_mul_b   (mul_b),
    .i_mul_p   (mul_p),
    .o_32_rr   (rr),
    .o_32_ii   (ii),
    .o_32_ri   (ri),
    .o_32_ir   (ir),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  fpu_mul #(.SIZE_DATA(W)) u_mul    (.i_32_a(mul_a), .i_32_b(mul_b), .o_32_mul(mul_p));
  fpu_mul #(.SIZE_DATA(W)) u_ref_rr (.i_32_a(a_re),  .i_32_b(w_re),  .o_32_mul(ref_rr));
  fpu_mul #(.SIZE_DATA(W)) u_ref_ii (.i_32_a(a_im),  .i_32_b(w_im),  .o_32_mul(ref_ii));
  fpu_mul #(.SIZE_DATA(W)) u_ref_ri (.i_32_a(a_re),  .i_32_b(w_im),  .o_32_mul(ref_ri));
  fpu_mul #(.SIZE_DATA(W)) u_ref_ir (.i_32_a(a_im),  .i_32_b(w_re),  .o_32_mul(ref_ir));

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a transfer happens on the next edge whenever valid && ready
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_valid) valid_cycles++;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got unexpected transfer want none at %0t", $time);
        end else begin
          prod_t e;
          e = sb.pop_front();
          check("sb_rr", rr, e.rr);
          check("sb_ii", ii, e.ii);
          check("sb_ri", ri, e.ri);
          check("sb_ir", ir, e.ir);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic accept(input vec_t v);
    int n;
    n = 0;
    while (!o_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", W'(o_ready), W'(1'b1));
    a_re = v.a_re;
    a_im = v.a_im;
    w_re = v.w_re;
    w_im = v.w_im;
    i_valid = 1'b1;
    sb.push_back(v.exp);
    tick();
    i_valid = 1'b0;
  endtask

  // Called just after the accept edge: o_valid must rise on the 4th edge after it
  task automatic wait_done();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lat_low", W'(o_valid), W'(1'b0));
      check("busy_ready", W'(o_ready), W'(1'b0));
    end
    tick();
    check("lat_high", W'(o_valid), W'(1'b1));
  endtask

  initial begin
    vecs[0] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
                '{32'h40400000, 32'h41000000, 32'h40800000, 32'h40c00000}};
    vecs[1] = '{32'hc0000000, 32'h00000000, 32'h3f000000, 32'hbf800000,
                '{32'hbf800000, 32'h80000000, 32'h40000000, 32'h00000000}};
    vecs[2] = '{32'h3fc00000, 32'h40000000, 32'h40000000, 32'hbfc00000,
                '{32'h40400000, 32'hc0400000, 32'hc0100000, 32'h40800000}};
    vecs[3] = '{32'h7f800000, 32'h00000000, 32'h00000000, 32'h3f800000,
                '{32'h7fc00000, 32'h00000000, 32'h7f800000, 32'h00000000}};
    busy_exp = '{32'hc0400000, 32'h00000000, 32'hc0800000, 32'h00000000};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    a_re = '0; a_im = '0; w_re = '0; w_im = '0;

    // Reset
    repeat (5) tick();
    check("rst_valid", W'(o_valid), W'(1'b0));
    check("rst_ready", W'(o_ready), W'(1'b1));
    check("rst_rr", rr, '0);
    check("rst_ii", ii, '0);
    check("rst_ri", ri, '0);
    check("rst_ir", ir, '0);
    check("rst_mul_a", mul_a, '0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", W'(o_ready), W'(1'b1));

    // Table vectors, downstream always ready
    for (int i = 0; i < 4; i++) begin
      accept(vecs[i]);
      check("mul0_a", mul_a, vecs[i].a_re);
      check("mul0_b", mul_b, vecs[i].w_re);
      wait_done();
      check("tab_rr", rr, vecs[i].exp.rr);
      check("tab_ii", ii, vecs[i].exp.ii);
      check("tab_ri", ri, vecs[i].exp.ri);
      check("tab_ir", ir, vecs[i].exp.ir);
      check("ref_rr", rr, ref_rr);
      check("ref_ii", ii, ref_ii);
      check("ref_ri", ri, ref_ri);
      check("ref_ir", ir, ref_ir);
      tick();
      check("ret_ready", W'(o_ready), W'(1'b1));
      check("ret_valid", W'(o_valid), W'(1'b0));
      check("idle_mul_a", mul_a, '0);
    end

    // Backpressure: hold for 3 cycles, then transfer
    i_ready = 1'b0;
    accept(vecs[0]);
    wait_done();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", W'(o_valid), W'(1'b1));
      check("bp_ready", W'(o_ready), W'(1'b0));
      check("bp_rr", rr, vecs[0].exp.rr);
      check("bp_ir", ir, vecs[0].exp.ir);
    end
    i_ready = 1'b1;
    tick();
    check("bp_ret_ready", W'(o_ready), W'(1'b1));
    check("bp_ret_valid", W'(o_valid), W'(1'b0));

    // Busy: a new set offered during MUL waits until the block is idle
    accept(vecs[0]);
    a_re = 32'hbf800000;
    a_im = 32'h00000000;
    i_valid = 1'b1;
    sb.push_back(busy_exp);
    tick();
    check("busy_ready_mul", W'(o_ready), W'(1'b0));
    check("busy_mul_a", mul_a, 32'h40000000);
    tick();
    tick();
    tick();
    check("busy_valid", W'(o_valid), W'(1'b1));
    check("busy_rr", rr, vecs[0].exp.rr);
    check("busy_ii", ii, vecs[0].exp.ii);
    tick();
    check("busy_idle_ready", W'(o_ready), W'(1'b1));
    tick();
    i_valid = 1'b0;
    check("busy_acc_ready", W'(o_ready), W'(1'b0));
    check("busy_acc_mul_a", mul_a, 32'hbf800000);
    wait_done();
    tick();
    check("busy_ret_ready", W'(o_ready), W'(1'b1));

    // Abort: reset while cnt=2
    begin
      int vc;
      accept(vecs[2]);
      tick();
      tick();
      check("abort_mul_a_cnt2", mul_a, vecs[2].a_re);
      check("abort_mul_b_cnt2", mul_b, vecs[2].w_im);
      vc = valid_cycles;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      check("abort_mul_a", mul_a, '0);
      check("abort_valid", W'(o_valid), W'(1'b0));
      check("abort_ready", W'(o_ready), W'(1'b1));
      repeat (6) tick();
      check("abort_no_valid", W'(valid_cycles), W'(vc));
      check("abort_idle_ready", W'(o_ready), W'(1'b1));
    end

    // Block still works after the abort
    accept(vecs[1]);
    wait_done();
    check("post_abort_rr", rr, vecs[1].exp.rr);
    tick();
    check("sb_drained", W'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
